// File: rtl/decoder_pkg.sv
// Shared types and default sizing for the LDPC decoder controller.
// The controller and the bench both import this.
package decoder_pkg;

  localparam int N_V_DEF      = 44;
  localparam int N_C_DEF      = 12;
  localparam int E_DEF        = 147;
  localparam int MAX_ITER_DEF = 5;
  localparam int SETTLE_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VN,
    ST_CN,
    ST_CHECK,
    ST_OUT,
    ST_DONE
  } state_t;

  // VN and CN are the only states whose length is set by the settle timer.
  function automatic logic is_layer_state(input state_t s);
    return (s == ST_VN) || (s == ST_CN);
  endfunction

endpackage

// File: rtl/decoder_ctrl_settle_timer.sv
// Counts the cycles a layer's combinational datapath has been settling.
// expired marks the last cycle of the layer.
module settle_timer
  import decoder_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == 4'(SETTLE - 1));

endmodule

// File: rtl/decoder_ctrl.sv
// Sequencing FSM for a layered LDPC decoder: issues load / variable-node /
// check-node / output capture enables and tracks iterations and convergence.
module decoder_ctrl
  import decoder_pkg::*;
#(
  parameter int N_V      = N_V_DEF,
  parameter int N_C      = N_C_DEF,
  parameter int E        = E_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int SETTLE   = SETTLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       syndrome_ok,
  output logic       load_en,
  output logic       vn_en,
  output logic       cn_en,
  output logic       out_en,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [3:0] iter_cnt
);

  if (MAX_ITER < 1 || MAX_ITER > 15 || SETTLE < 1 || SETTLE > 15 ||
      N_V < 1 || N_C < 1 || E < 1) begin : g_param_check
    $error("decoder_ctrl: illegal parameter value");
  end

  state_t     state_q, state_d;
  logic [3:0] iter_cnt_q, iter_cnt_d;
  logic       converged_q, converged_d;
  logic       settle_en, settle_clr, settle_expired;

  // Any state change zeroes the timer, so each VN/CN entry starts fresh.
  assign settle_en  = is_layer_state(state_q);
  assign settle_clr = (state_d != state_q);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (settle_clr),
    .en      (settle_en),
    .expired (settle_expired)
  );

  always_comb begin
    state_d     = state_q;
    iter_cnt_d  = iter_cnt_q;
    converged_d = converged_q;
    load_en     = 1'b0;
    vn_en       = 1'b0;
    cn_en       = 1'b0;
    out_en      = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          iter_cnt_d  = 4'd0;
          converged_d = 1'b0;
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        state_d = ST_VN;
      end
      ST_VN: begin
        if (settle_expired) begin
          vn_en   = 1'b1;
          state_d = ST_CN;
        end
      end
      ST_CN: begin
        if (settle_expired) begin
          cn_en   = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        iter_cnt_d = iter_cnt_q + 4'd1;
        if (syndrome_ok) begin
          converged_d = 1'b1;
          state_d     = ST_OUT;
        end else if (iter_cnt_q + 4'd1 == 4'(MAX_ITER)) begin
          converged_d = 1'b0;
          state_d     = ST_OUT;
        end else begin
          state_d = ST_VN;
        end
      end
      ST_OUT: begin
        out_en  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including enables already decoded this cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      iter_cnt_d  = iter_cnt_q;
      converged_d = 1'b0;
      load_en     = 1'b0;
      vn_en       = 1'b0;
      cn_en       = 1'b0;
      out_en      = 1'b0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      iter_cnt_q  <= 4'd0;
      converged_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_cnt_q  <= iter_cnt_d;
      converged_q <= converged_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign converged = converged_q;
  assign iter_cnt  = iter_cnt_q;

endmodule

// File: doc/decoder_ctrl.md
DECODER_CTRL -- requirements
Module: decoder_ctrl

Interface
REQ-001 Parameter N_V, default 44, number of variable nodes in the Tanner graph.
REQ-002 Parameter N_C, default 12, number of check nodes.
REQ-003 Parameter E, default 147, number of Tanner-graph edges.
REQ-004 Parameter MAX_ITER, default 5, maximum decoding iterations; legal range 1..15.
REQ-005 Parameter SETTLE, default 2, cycles each layer's combinational datapath is given before capture; legal range 1..15.
REQ-006 clk  input  1  single system clock; all state changes on posedge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  request to decode the frame present on the channel-LLR bus.
REQ-009 abort  input  1  synchronous cancel of the frame in flight.
REQ-010 syndrome_ok  input  1  all N_C parity checks satisfied by current hard decisions (combinational from datapath).
REQ-011 load_en  output  1  capture channel LLRs into edge registers.
REQ-012 vn_en  output  1  capture variable-node layer result into edge registers.
REQ-013 cn_en  output  1  capture check-node layer result into edge registers.
REQ-014 out_en  output  1  capture final hard decisions into output register.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 converged  output  1  valid with done; 1 when exit was caused by syndrome_ok.
REQ-018 iter_cnt  output  4  completed iterations of current/last frame.

Function
REQ-019 FSM states: IDLE, LOAD, VN, CN, CHECK, OUT, DONE; encoding one-hot or binary, implementer's choice.
REQ-020 IDLE: start=1 -> LOAD next cycle; iter_cnt cleared to 0 on that same edge; otherwise stay.
REQ-021 LOAD: load_en=1 for exactly one cycle -> VN.
REQ-022 VN: settle counter counts SETTLE cycles; vn_en=1 only in final VN cycle -> CN.
REQ-023 CN: same settle rule; cn_en=1 only in final CN cycle -> CHECK.
REQ-024 CHECK: one cycle; iter_cnt increments; if syndrome_ok=1 -> OUT with converged latched 1; else if iter_cnt+1==MAX_ITER -> OUT with converged latched 0; else -> VN.
REQ-025 syndrome_ok is sampled only in CHECK; value in other states is ignored.
REQ-026 OUT: out_en=1 one cycle -> DONE.
REQ-027 DONE: done=1 one cycle -> IDLE; iter_cnt and converged hold until next start.
REQ-028 Frame latency start-to-done = 3 + k*(2*SETTLE+1) cycles, k = iterations executed (default, no early exit: 28).
REQ-029 At most one enable among load_en, vn_en, cn_en, out_en is high in any cycle.
REQ-030 start while busy=1 is ignored (not queued); start held high in DONE cycle does not start a frame until IDLE.
REQ-031 abort=1 in any non-IDLE state -> IDLE next cycle, no enable asserted that cycle, no done pulse, converged cleared; abort has priority over every other transition; abort in IDLE ignored.
REQ-032 Settle counter resets to 0 on every entry into VN or CN.

Reset
REQ-033 rst=0 forces IDLE immediately, independent of clk.
REQ-034 Reset values: all enables 0, busy 0, done 0, converged 0, iter_cnt 0, settle counter 0.
REQ-035 Reset mid-frame discards the frame; first start after rst release is accepted normally.

Structure
REQ-036 State typedef, default N_V/N_C/E, MAX_ITER and SETTLE constants live in shared package decoder_pkg.
REQ-037 Settle counter implemented as sub-module settle_timer (inputs clr, en; output expired), instantiated once.
REQ-038 No datapath arithmetic in this block; it only drives enables to the variable-node and check-node layers.

Verification
REQ-039 Defaults, syndrome_ok=0 always, start pulse -> load_en at cycle 1, vn_en at cycles 3,8,..., done at cycle 28, iter_cnt=5, converged=0.
REQ-040 syndrome_ok=1 from cycle 6 -> exit after first CHECK, out_en at cycle 7, done at cycle 8, iter_cnt=1, converged=1.
REQ-041 abort=1 during second CN -> IDLE next cycle, no out_en, no done, busy=0.
REQ-042 rst=0 asserted between clock edges mid-VN -> outputs at reset values before next posedge; new start decodes normally.
REQ-043 start held high continuously -> back-to-back frames, each with one IDLE cycle between done and next load_en.
REQ-044 SETTLE=1, MAX_ITER=1 -> done at cycle 6, iter_cnt=1; one-hot-or-zero check on enables every cycle.
